countdown_controller: RTL
=========================

# countdown_controller

Sequencing controller for the board's down-counter datapath: loads a start value, decrements it once per prescaled tick, and supports pause, clear and terminal-count signalling. It replaces free-running divided-clock counting with a single-clock, clock-enable-driven design. It sits between the KEY/SW inputs and the LEDR/HEX display logic in the DE1_SoC top level.

## Interface
- WIDTH, 4, count width in bits
- TICK_DIV, 25_000_000, clk cycles per decrement tick (≥2); 2 Hz at CLOCK_50
- clk  input  1  system clock, rising edge; the top level drives it from CLOCK_50
- reset  input  1  asynchronous, active-low reset
- start  input  1  synchronous pulse; loads load_val and begins counting
- pause  input  1  level; while high, counting is frozen
- clear  input  1  synchronous pulse; abort to IDLE
- load_val  input  WIDTH  start value, sampled on accepted start or reload
- count  output  WIDTH  current count (registered)
- busy  output  1  high in RUN or PAUSED
- done  output  1  one-cycle pulse on reaching terminal count
- tick  output  1  one-cycle prescaler strobe, RUN only

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset (reset=0): state IDLE, count 0, busy 0, done 0, tick 0, prescaler 0. Applies immediately, independent of clk.
- Priority each cycle: clear > start > pause > tick.
- clear in any state: next state IDLE, count 0, prescaler 0, and no done.
- start in IDLE or DONE:
  - load_val ≠ 0: count ← load_val, prescaler ← 0, next state RUN.
  - load_val = 0: count ← 0, done pulses, next state DONE.
- start in RUN or PAUSED is ignored.
- RUN with pause=1: next state PAUSED. The prescaler holds and no decrement occurs that cycle, even if a tick would have fired.
- PAUSED with pause=0: next state RUN. The prescaler resumes from its held value.
- RUN, prescaler = TICK_DIV-1, pause=0:
  - prescaler ← 0 and tick=1 for that cycle.
  - count > 1: count ← count-1.
  - count = 1: count ← 0, done=1, next state DONE.
- DONE holds count=0 until start or clear.
- Arithmetic is unsigned modulo 2^WIDTH. Count never wraps below 0 because the terminal transition occurs at 1.
- The prescaler is a ceil(log2(TICK_DIV))-bit counter.

## Timing
- All outputs are registered.
- start at edge n: count=load_val and busy=1 after edge n.
- First decrement occurs TICK_DIV cycles after entering RUN. Later decrements follow every TICK_DIV RUN cycles.
- done asserts in the same cycle count first shows 0, for exactly one cycle. busy deasserts in that same cycle.
- A tick occurring in the same cycle as a pause or clear edge is discarded.
- Paused cycles do not count toward TICK_DIV.
- Reset deasserting mid-operation leaves the block in IDLE. No pending done is emitted.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined:
  - At terminal count in RUN, count ← load_val (sampled that cycle) and the state stays RUN.
  - done pulses and busy stays 1.
  - If load_val = 0 at reload, go to DONE as without the macro.
- COUNTDOWN_AUTORELOAD_EN undefined: single-shot behaviour as in Operation.

## Structure
- Package countdown_pkg:
  - state enum (IDLE, RUN, PAUSED, DONE)
  - default TICK_DIV constant
  - function for prescaler width
- Sub-module tick_prescaler:
  - parameter TICK_DIV; ports clk, reset, en, clr, tick.
  - Counts while en=1, holds while en=0, zeroes on clr.
  - Strobes tick at TICK_DIV-1.
- countdown_controller instantiates it with en = (state==RUN && !pause).

## Test plan
Bench uses WIDTH=4 and TICK_DIV=4.
- Count-down: load_val=3, start pulse → count 3, then 2, 1, 0 at 4-cycle intervals; done high exactly one cycle with count=0; busy 1→0 at the same cycle.
- Pause: load_val=5, start, pause high 6 cycles after 2 RUN cycles → count stays 5 during pause; decrement to 4 occurs 2 RUN cycles after pause drops.
- Zero load: load_val=0, start → next cycle done=1, count=0, busy never 1, state DONE.
- Clear vs start: in RUN with count=7, assert clear and start together → next cycle IDLE, count=0, busy=0, done=0.
- Async reset: drive reset low between clk edges mid-RUN → count, busy, done and tick are 0 immediately. After release, start with load_val=2 counts 2,1,0 normally.
- COUNTDOWN_AUTORELOAD_EN: load_val=2, start → count sequence 2,1,2,1,…; done pulses at each reload and busy stays 1. Changing load_val to 0 before the next reload → DONE, count=0.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg: state encoding, default prescale ratio and prescaler sizing
// shared by countdown_controller and tick_prescaler.
package countdown_pkg;

  // 2 Hz decrement rate from the 50 MHz board clock.
  localparam int unsigned DEFAULT_TICK_DIV = 25_000_000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    PAUSED = ST_PAUSED,
    DONE   = ST_DONE
  } state_t;

  // ceil(log2(div)), never less than one bit.
  function automatic int unsigned prescale_width(input int unsigned div);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(div)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: clock-enable counter that strobes tick on its last state
// (TICK_DIV-1); holds while en is low, zeroes on clr.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    PW   = prescale_width(TICK_DIV);
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_controller.sv
// countdown_controller: loads a start value and decrements it once per prescaled
// tick with pause/clear/done; COUNTDOWN_AUTORELOAD_EN reloads load_val at terminal count.
module countdown_controller
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic             busy_nx, done_nx, tick_nx;
  logic             start_ok, pre_en, pre_clr, pre_tick;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign pre_en   = (state == RUN) && !pause;
  assign pre_clr  = clear || start_ok;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (pre_tick)
  );

  // Priority: clear > start > pause > tick.
  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = 1'b0;
    tick_nx  = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (start_ok) begin
      if (load_val != '0) begin
        count_nx = load_val;
        state_nx = RUN;
      end else begin
        count_nx = '0;
        done_nx  = 1'b1;
        state_nx = DONE;
      end
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nx = PAUSED;
          end else if (pre_tick) begin
            tick_nx = 1'b1;
            if (count > WIDTH'(1)) begin
              count_nx = count - WIDTH'(1);
            end else begin
              done_nx = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (load_val != '0) begin
                count_nx = load_val;
              end else begin
                count_nx = '0;
                state_nx = DONE;
              end
`else
              count_nx = '0;
              state_nx = DONE;
`endif
            end
          end
        end
        PAUSED: begin
          if (!pause) state_nx = RUN;
        end
        default: ;
      endcase
    end
    busy_nx = (state_nx == RUN) || (state_nx == PAUSED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      tick  <= tick_nx;
    end
  end

endmodule
